uart_tx_frame: RTL
==================

// Module: uart_tx_frame
// PURPOSE
//  Parametrised UART transmitter; next generation of the fixed 8N1 TX block.
//  Serialises one word per frame: start bit, DATA_BITS data LSB-first, optional parity, 1 or 2 stop bits.
//  Bit timing comes from an external oversampling tick; valid/ready handshake on the parallel side.
//  Sits between a host/FIFO and the UART pin, beside the RX module, sharing the same baud tick generator.
// PARAMETERS
//  DATA_BITS   8   data bits per frame, legal 5..9
//  OVERSAMPLE  16  baud_x16_en ticks per bit, legal 4..64 (counter width = $clog2(OVERSAMPLE))
//  PARITY_EN   0   1 = parity bit inserted after the data bits
//  PARITY_ODD  0   0 = even parity, 1 = odd; ignored when PARITY_EN=0
//  STOP_BITS   1   stop bits per frame, legal 1 or 2
// PORTS
//  clk          in   1          system clock; all logic on posedge
//  rst          in   1          synchronous, active-high reset
//  baud_x16_en  in   1          one-clk oversampling tick, OVERSAMPLE per bit period
//  tx_valid     in   1          tx_data holds a word to send
//  tx_data      in   DATA_BITS  parallel word, sampled on handshake
//  tx_ready     out  1          block can accept a word this cycle
//  serial_out   out  1          UART line, idle high
//  tx_active    out  1          high from handshake until the frame's last stop bit ends
//  data_sent    out  1          one-clk pulse at end of frame
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, serial_out=1, tx_ready=1, tx_active=0, data_sent=0,
//   counters zeroed; overrides any frame in progress (line returns high next edge, word lost).
//  Handshake: word accepted on a posedge with tx_valid && tx_ready, not gated by baud tick.
//   Same edge: tx_data latched to shift reg, tx_ready->0, tx_active->1, state->START.
//   tx_ready=1 only in IDLE; tx_data/tx_valid ignored otherwise.
//  States: IDLE -> START -> DATA -> [PARITY if PARITY_EN] -> STOP -> IDLE.
//  Bit timing: serial_out changes only on ticked edges. First ticked edge after accept drives
//   serial_out=0; each bit then held exactly OVERSAMPLE ticks (tick counter 0..OVERSAMPLE-1),
//   next bit driven on the tick where counter wraps to 0.
//  DATA: bit index 0..DATA_BITS-1, LSB first; index resets to 0 on leaving DATA.
//  PARITY: even = ^data, odd = ~^data, computed from the latched word.
//  STOP: serial_out=1 for STOP_BITS*OVERSAMPLE ticks. On the tick ending the last stop bit:
//   state->IDLE, tx_active->0, tx_ready->1, data_sent=1 for that one clk only.
//  Frame length from first low tick = (1+DATA_BITS+PARITY_EN+STOP_BITS)*OVERSAMPLE ticks.
//  Back-to-back: tx_valid held high -> next word accepted on the edge after data_sent; the next
//   start bit begins at the next tick, so no idle gap beyond that one tick.
//  Non-tick cycles: state, counters and serial_out hold; only the handshake and data_sent
//   clear are active.
//  Illegal state encodings recover to IDLE with serial_out=1.
// STRUCTURE
//  Shared package uart_pkg: state encoding localparams (IDLE/START/DATA/PARITY/STOP), width
//   helper for the tick counter, parity-mode constants; the RX successor reuses them.
//  Single module, no sub-module: one registered FSM with tick counter, bit index, shift reg;
//   parity is a reduction XOR.
// TESTING
//  Reset then idle 100 ticks -> serial_out=1, tx_ready=1, tx_active=0, data_sent never pulses.
//  8N1 OVERSAMPLE=16, send 8'hA5 -> line 0,1,0,1,0,0,1,0,1,1 each 16 ticks; one data_sent pulse at tick 160.
//  DATA_BITS=7 PARITY_EN=1 PARITY_ODD=0 STOP_BITS=2, send 7'h55 -> parity bit 0, frame 11*16 ticks.
//  Same config PARITY_ODD=1, send 7'h07 -> parity bit 0; send 7'h03 -> parity bit 1.
//  tx_valid held high with 8'h01 then 8'hFF -> second start bit on the tick after the first
//   data_sent; tx_data changes mid-frame have no effect on the line.
//  rst asserted mid-DATA of 8'h3C -> next edge serial_out=1, tx_ready=1; new word 8'hC3 sent intact.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, parity-mode constants and
// the counter width helper used by both the TX and RX blocks.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic PAR_MODE_EVEN = 1'b0;
    localparam logic PAR_MODE_ODD  = 1'b1;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start bit, LSB-first data, optional parity,
// 1 or 2 stop bits, timed by an external oversampling tick.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_x16_en,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 serial_out,
    output logic                 tx_active,
    output logic                 data_sent
);

    localparam int unsigned CNT_W = cnt_width(OVERSAMPLE);
    localparam int unsigned IDX_W = cnt_width(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic PAR_MODE = (PARITY_ODD != 0) ? PAR_MODE_ODD : PAR_MODE_EVEN;

    tx_state_t            state, state_next;
    logic [CNT_W-1:0]     tick_cnt, tick_cnt_next;
    logic [IDX_W-1:0]     bit_idx, bit_idx_next;
    logic [IDX_W-1:0]     idx_inc;
    logic                 stop_idx, stop_idx_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 line_q, line_next;
    logic                 sent_q, sent_next;
    logic                 accept, bit_end, last_stop, parity_bit;

    assign accept     = tx_valid && (state == ST_IDLE);
    assign bit_end    = baud_x16_en && (tick_cnt == CNT_LAST);
    assign last_stop  = (STOP_BITS < 2) || stop_idx;
    assign idx_inc    = bit_idx + IDX_W'(1);
    // PAR_MODE is 0 for even and 1 for odd, so it folds straight into the XOR.
    assign parity_bit = (^shift_reg) ^ PAR_MODE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            shift_reg <= '0;
            line_q    <= 1'b1;
            sent_q    <= 1'b0;
        end else begin
            state     <= state_next;
            tick_cnt  <= tick_cnt_next;
            bit_idx   <= bit_idx_next;
            stop_idx  <= stop_idx_next;
            shift_reg <= shift_next;
            line_q    <= line_next;
            sent_q    <= sent_next;
        end
    end

    always_comb begin
        state_next    = state;
        tick_cnt_next = tick_cnt;
        bit_idx_next  = bit_idx;
        stop_idx_next = stop_idx;
        shift_next    = accept ? tx_data : shift_reg;
        line_next     = line_q;
        sent_next     = 1'b0;

        if (baud_x16_en && state != ST_IDLE) begin
            tick_cnt_next = bit_end ? '0 : tick_cnt + CNT_W'(1);
        end

        case (state)
            ST_IDLE: begin
                tick_cnt_next = '0;
                bit_idx_next  = '0;
                stop_idx_next = 1'b0;
                line_next     = 1'b1;
                if (accept) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                // Line still high here means the start bit has not been driven yet.
                if (baud_x16_en && line_q) begin
                    line_next     = 1'b0;
                    tick_cnt_next = '0;
                end else if (bit_end) begin
                    line_next  = shift_reg[0];
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx == IDX_LAST) begin
                        bit_idx_next = '0;
                        if (PARITY_EN != 0) begin
                            line_next  = parity_bit;
                            state_next = ST_PARITY;
                        end else begin
                            line_next  = 1'b1;
                            state_next = ST_STOP;
                        end
                    end else begin
                        bit_idx_next = idx_inc;
                        line_next    = shift_reg[idx_inc];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    line_next  = 1'b1;
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (last_stop) begin
                        stop_idx_next = 1'b0;
                        sent_next     = 1'b1;
                        state_next    = ST_IDLE;
                    end else begin
                        stop_idx_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next    = ST_IDLE;
                tick_cnt_next = '0;
                bit_idx_next  = '0;
                stop_idx_next = 1'b0;
                line_next     = 1'b1;
            end
        endcase
    end

    always_comb begin
        tx_ready   = (state == ST_IDLE);
        tx_active  = (state != ST_IDLE);
        serial_out = line_q;
        data_sent  = sent_q;
    end

endmodule
